// File: rtl/sqdiff_frame_acc.sv
// Frame accumulator for the squared-difference result stream: groups N signed
// samples into a frame and presents sum/max/min on a registered valid/ready port.
module sqdiff_frame_acc #(
  parameter int N  = 8,
  parameter int SW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [12:0]   in_data,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [SW-1:0] out_sum,
  output logic signed [12:0]   out_max,
  output logic signed [12:0]   out_min,
  output logic                 ovf
);

  localparam int DATA_W = 13;
  localparam int CW     = $clog2(N);

  typedef enum logic {S_EMPTY, S_ACC} state_t;

  function automatic logic signed [SW-1:0] sext(input logic signed [DATA_W-1:0] x);
    return {{(SW-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DATA_W-1:0] smin(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [SW-1:0]      acc_q, acc_d;
  logic signed [DATA_W-1:0]  cur_max_q, cur_max_d;
  logic signed [DATA_W-1:0]  cur_min_q, cur_min_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [SW-1:0]      out_sum_q, out_sum_d;
  logic signed [DATA_W-1:0]  out_max_q, out_max_d;
  logic signed [DATA_W-1:0]  out_min_q, out_min_d;
  logic                      ovf_q, ovf_d;

  logic signed [SW-1:0]      sum_next;
  logic signed [DATA_W-1:0]  max_next;
  logic signed [DATA_W-1:0]  min_next;

  assign sum_next = acc_q + sext(in_data);
  assign max_next = smax(cur_max_q, in_data);
  assign min_next = smin(cur_min_q, in_data);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    cur_max_d   = cur_max_q;
    cur_min_d   = cur_min_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_max_d   = out_max_q;
    out_min_d   = out_min_q;
    ovf_d       = ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // clear wins over a same-cycle sample; the output holding register is untouched
    if (clear) begin
      state_d = S_EMPTY;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else if (in_valid) begin
      if (state_q == S_EMPTY) begin
        state_d   = S_ACC;
        cnt_d     = CW'(1);
        acc_d     = sext(in_data);
        cur_max_d = in_data;
        cur_min_d = in_data;
      end else if (cnt_q == CW'(N-1)) begin
        state_d     = S_EMPTY;
        cnt_d       = '0;
        acc_d       = sum_next;
        out_sum_d   = sum_next;
        out_max_d   = max_next;
        out_min_d   = min_next;
        out_valid_d = 1'b1;
        // a result still held without a handshake is being replaced
        if (out_valid_q && !out_ready) begin
          ovf_d = 1'b1;
        end
      end else begin
        cnt_d     = cnt_q + CW'(1);
        acc_d     = sum_next;
        cur_max_d = max_next;
        cur_min_d = min_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      cnt_q       <= '0;
      acc_q       <= '0;
      cur_max_q   <= '0;
      cur_min_q   <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_max_q   <= '0;
      out_min_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      cur_max_q   <= cur_max_d;
      cur_min_q   <= cur_min_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_max_q   <= out_max_d;
      out_min_q   <= out_min_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_max   = out_max_q;
  assign out_min   = out_min_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sqdiff_frame_acc.sv
// Directed bench for sqdiff_frame_acc: an N=4 instance for framing, handshake,
// overrun, clear and reset, and an N=8 instance for sum-width extremes.
module tb_sqdiff_frame_acc;

  logic clk;
  logic rst;

  logic               a_iv, a_clr, a_rdy, a_ov, a_ovf;
  logic signed [12:0] a_id, a_max, a_min;
  logic signed [15:0] a_sum;

  logic               b_iv, b_clr, b_rdy, b_ov, b_ovf;
  logic signed [12:0] b_id, b_max, b_min;
  logic signed [15:0] b_sum;
  logic [15:0]        b_raw;

  int n_cmp;
  int n_err;

  sqdiff_frame_acc #(.N(4), .SW(16)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_data(a_id), .clear(a_clr),
    .out_valid(a_ov), .out_ready(a_rdy), .out_sum(a_sum), .out_max(a_max),
    .out_min(a_min), .ovf(a_ovf)
  );

  sqdiff_frame_acc #(.N(8), .SW(16)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_data(b_id), .clear(b_clr),
    .out_valid(b_ov), .out_ready(b_rdy), .out_sum(b_sum), .out_max(b_max),
    .out_min(b_min), .ovf(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int v);
    a_iv = 1'b1;
    a_id = 13'(v);
    tick();
    a_iv = 1'b0;
  endtask

  task automatic send_b(input int v);
    b_iv = 1'b1;
    b_id = 13'(v);
    tick();
    b_iv = 1'b0;
  endtask

  task automatic chk_a(input string tag, input int v, input int s, input int mx,
                       input int mn, input int o);
    chk({tag, "_valid"}, int'(a_ov), v);
    chk({tag, "_sum"}, int'(a_sum), s);
    chk({tag, "_max"}, int'(a_max), mx);
    chk({tag, "_min"}, int'(a_min), mn);
    chk({tag, "_ovf"}, int'(a_ovf), o);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    a_iv = 1'b0; a_id = '0; a_clr = 1'b0; a_rdy = 1'b1;
    b_iv = 1'b0; b_id = '0; b_clr = 1'b0; b_rdy = 1'b1;
    #2;
    chk_a("rst_init", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // basic contiguous frame
    send_a(36); send_a(9); send_a(-25);
    chk("basic_pre_valid", int'(a_ov), 0);
    send_a(0);
    chk_a("basic", 1, 20, 36, -25, 0);
    tick();
    chk("basic_drop", int'(a_ov), 0);

    // gapped frame
    send_a(16); tick(); tick();
    send_a(1);  tick(); tick();
    send_a(-1); tick(); tick();
    chk("gap_pre_valid", int'(a_ov), 0);
    send_a(4);
    chk_a("gap", 1, 20, 16, -1, 0);
    tick();
    chk("gap_drop", int'(a_ov), 0);

    // overrun: A then B back-to-back without a consumer
    a_rdy = 1'b0;
    send_a(1); send_a(1); send_a(1); send_a(1);
    chk_a("ovr_a", 1, 4, 1, 1, 0);
    send_a(2); send_a(2); send_a(2); send_a(2);
    chk_a("ovr_b", 1, 8, 2, 2, 1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk_a("ovr_clr", 1, 8, 2, 2, 0);
    a_rdy = 1'b1;
    tick();
    chk("ovr_drain", int'(a_ov), 0);
    a_rdy = 1'b0;
    send_a(1); send_a(1); send_a(1); send_a(1);
    chk_a("sim_a", 1, 4, 1, 1, 0);
    send_a(2); send_a(2); send_a(2);
    a_rdy = 1'b1;
    send_a(2);
    chk_a("sim_b", 1, 8, 2, 2, 0);
    tick();
    chk("sim_drop", int'(a_ov), 0);

    // clear mid-frame with a pending result
    a_rdy = 1'b0;
    send_a(7); send_a(7); send_a(7); send_a(7);
    chk_a("pend", 1, 28, 7, 7, 0);
    send_a(5); send_a(5);
    a_clr = 1'b1;
    send_a(99);
    a_clr = 1'b0;
    tick();
    chk_a("clr_pend", 1, 28, 7, 7, 0);
    a_rdy = 1'b1;
    tick();
    chk("clr_drain", int'(a_ov), 0);
    send_a(3); send_a(3); send_a(3); send_a(3);
    chk_a("clr_frame", 1, 12, 3, 3, 0);
    tick();

    // width extremes on N=8
    for (int i = 0; i < 8; i++) send_b(-4096);
    b_raw = b_sum;
    chk("neg_valid", int'(b_ov), 1);
    chk("neg_sum", int'(b_sum), -32768);
    chk("neg_raw", int'(b_raw), 32'h8000);
    chk("neg_max", int'(b_max), -4096);
    chk("neg_min", int'(b_min), -4096);
    for (int i = 0; i < 8; i++) send_b(4095);
    chk("pos_valid", int'(b_ov), 1);
    chk("pos_sum", int'(b_sum), 32760);
    chk("pos_max", int'(b_max), 4095);
    chk("pos_min", int'(b_min), 4095);

    // reset mid-frame with a pending result
    a_rdy = 1'b0;
    send_a(1); send_a(2); send_a(3); send_a(4);
    chk_a("pre_rst", 1, 10, 4, 1, 0);
    send_a(9); send_a(9);
    rst = 1'b0;
    #1;
    chk_a("async_rst", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    a_rdy = 1'b1;
    send_a(4); send_a(4); send_a(4);
    chk("post_rst_pre_valid", int'(a_ov), 0);
    send_a(4);
    chk_a("post_rst", 1, 16, 4, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sqdiff_frame_acc.md
# sqdiff_frame_acc

Downstream consumer of the squared-difference pipeline. Accepts the signed 13-bit result stream one sample per qualified cycle, groups samples into fixed frames of N, and for each completed frame presents the frame sum, maximum and minimum on a registered valid/ready output. The input side has no backpressure, matching the free-running upstream stage. An unconsumed result that is overwritten sets a sticky overrun flag.

## Interface
- N, 8: samples per frame, legal range 2..256.
- SW, 16: sum width; must satisfy SW >= 13 + clog2(N).
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is a sample this cycle.
- in_data  in  13  signed sample from the squared-difference stage.
- clear  in  1  synchronous: abandon the in-progress frame and clear ovf.
- out_valid  out  1  frame result held on the out_* ports.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  SW  signed, sign-extended sum of the N samples.
- out_max  out  13  signed maximum of the frame.
- out_min  out  13  signed minimum of the frame.
- ovf  out  1  sticky: an unconsumed result was overwritten.

## Operation
- State machine has two states.
  - EMPTY: no samples in the current frame.
  - ACC: 1..N-1 samples accumulated.
- Internal registers: cnt (clog2(N) bits), acc (SW bits), cur_max, cur_min.
- Accepted sample: in_valid=1 and clear=0 at a rising edge.
- Sample accepted in EMPTY:
  - acc ← sext(in_data); cur_max ← in_data; cur_min ← in_data; cnt ← 1.
  - Go to ACC. For N=1 this would complete immediately, so N=1 is illegal.
- Sample accepted in ACC with cnt < N-1:
  - acc ← acc + sext(in_data); cnt ← cnt+1.
  - Update cur_max and cur_min with a signed compare.
- Sample accepted in ACC with cnt = N-1 (frame completes):
  - out_sum ← acc + sext(in_data).
  - out_max and out_min ← final values that include this sample.
  - out_valid ← 1; go to EMPTY; cnt ← 0.
- Arithmetic: all compares and additions are two's-complement signed. With legal SW the sum cannot wrap, so no saturation logic is present.
- Output handshake:
  - A transfer occurs when out_valid=1 and out_ready=1 at an edge.
  - out_valid falls on that edge unless a new frame completes on the same edge.
  - out_* stay stable while out_valid=1 and no frame completes.
- Overrun: a frame completes while out_valid=1 and out_ready=0.
  - out_* are overwritten with the new frame; out_valid stays 1; ovf ← 1.
- Completion and transfer on the same edge: new result loads, out_valid stays 1, ovf unchanged.
- clear:
  - Returns to EMPTY, zeroes cnt and acc, and sets ovf ← 0.
  - Any in_valid sample in the same cycle is discarded.
  - out_valid and out_* are not affected; a pending result remains available for handshake.
- ovf clears only on reset or clear.

## Timing
- Reset (rst=0, asynchronous): state=EMPTY, cnt=0, acc=0, cur_max=0, cur_min=0, out_valid=0, out_sum=0, out_max=0, out_min=0, ovf=0.
- Release is synchronous to clk: the first sample is accepted at the first rising edge with rst=1.
- Reset asserted mid-frame discards the partial frame and any pending output immediately.
- Latency: out_valid is high in the cycle after the edge that accepts the Nth sample. No combinational path exists from any input to any output.
- Gaps: cycles with in_valid=0 hold all frame state; frames may span any number of cycles.
- Throughput: one sample per cycle sustained. Back-to-back frames produce one result every N cycles.
- ovf rises in the cycle after the overwrite edge.

## Test plan
- Reset: drive rst=0 mid-frame with out_valid=1 → all outputs 0 immediately. After release with N=4, the next 4 samples form a fresh frame.
- Basic frame, N=4, contiguous in_valid, samples 36, 9, -25, 0, out_ready=1 → one cycle after the 4th sample: out_valid=1, out_sum=20, out_max=36, out_min=-25, ovf=0. out_valid drops on the next edge.
- Gapped input, N=4, samples 16, 1, -1, 4 with 2-cycle in_valid gaps between them → out_sum=20, out_max=16, out_min=-1, out_valid exactly one cycle after the 4th sample.
- Overrun and simultaneous events, N=4:
  - Frame A = 1,1,1,1 and frame B = 2,2,2,2 back-to-back with out_ready=0 → after B: out_sum=8, out_max=out_min=2, ovf=1.
  - Repeat after clear with out_ready=1 on B's completion edge → out_sum=8, out_valid stays 1, ovf=0.
- Width extremes, N=8, SW=16:
  - Eight samples of -4096 → out_sum=-32768 (0x8000), out_max=out_min=-4096.
  - Eight samples of 4095 → out_sum=32760.
- clear mid-frame, N=4: samples 5, 5, then clear with in_valid=1 and data 99, then samples 3, 3, 3, 3 → out_sum=12, out_max=out_min=3. The sample 99 is never counted, and a result pending before the clear remains on the outputs until handshaked.
